// File: rtl/fifo_ahb_writer.sv
// ---------------------------------------------------------------------------
// fifo_ahb_writer
//
// Drains a FIFO read port into AHB-lite single write transfers. Each popped
// word becomes one NONSEQ/SINGLE/word write. Consecutive writes go to
// incrementing addresses that wrap inside a window of WIN_WORDS words
// starting at BASE_ADDR. Words are not pipelined: every word passes through
// IDLE -> FETCH -> ADDR -> DATA before the next pop is considered.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   enable            permits new pops (looked at only while idle)
//   fifo_empty        FIFO empty flag
//   fifo_rd_en        one-cycle pop strobe
//   fifo_rd_data      FIFO data, valid the cycle after fifo_rd_en
//   HADDR..HWDATA     AHB-lite master outputs
//   HREADY, HRESP     AHB-lite slave response
//   busy              high whenever the FSM is not idle
//   err               sticky bus-error flag
//   xfer_count        number of writes completed with OKAY (wraps)
//   state_dbg         current FSM state encoding, for observation only
//
// Handshake: an AHB phase completes on a rising edge where HREADY=1. While
// HREADY=0 the current phase is extended and every signal this block drives
// for that phase stays unchanged. An ERROR response is only acted upon in
// the cycle where HREADY=1 and HRESP=1; the preceding HREADY=0 cycle is an
// ordinary wait state.
// ---------------------------------------------------------------------------
module fifo_ahb_writer #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                WIN_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              busy,
  output logic              err,
  output logic [15:0]       xfer_count,
  output logic [2:0]        state_dbg
);

  localparam int         IDX_W        = $clog2(WIN_WORDS);
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [DATA_W-1:0]   data_q;
  // Word index inside the window; its natural wrap gives the modulo-window
  // address without needing BASE_ADDR to be window-aligned.
  logic [IDX_W-1:0]    widx_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                pop;
  logic                ok_done;
  logic                err_done;

  assign addr_q = BASE_ADDR + ADDR_W'({widx_q, 2'b00});

  // Next-state and control decode
  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    ok_done  = 1'b0;
    err_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && !fifo_empty) begin
          pop     = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_FETCH: state_n = S_ADDR;
      S_ADDR: begin
        if (HREADY) state_n = S_DATA;
      end
      S_DATA: begin
        if (HREADY) begin
          if (HRESP) begin
            err_done = 1'b1;
            state_n  = S_HALT;
          end else begin
            ok_done  = 1'b1;
            state_n  = S_IDLE;
          end
        end
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      data_q     <= '0;
      widx_q     <= '0;
      xfer_count <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_FETCH) data_q <= fifo_rd_data;
      if (ok_done) begin
        widx_q     <= widx_q + IDX_W'(1);
        xfer_count <= xfer_count + 16'd1;
      end
      if (err_done) err <= 1'b1;
    end
  end

  // A pop is never issued in a reset cycle so no word is lost at reset exit.
  assign fifo_rd_en = pop && !rst;
  assign HTRANS     = (state == S_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
  assign HWRITE     = (state == S_ADDR);
  assign HADDR      = addr_q;
  assign HWDATA     = data_q;
  assign HSIZE      = 3'b010;
  assign HBURST     = 3'b000;
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_fifo_ahb_writer.sv
// ---------------------------------------------------------------------------
// tb_fifo_ahb_writer
//
// Drives fifo_ahb_writer with a queue-backed FIFO model and a randomizing
// AHB slave model. A reference model checks every pop, address phase and
// data phase against the expected write stream: k-th OKAY write goes to
// BASE + (k mod WIN)*4 and carries the k-th word pushed into the FIFO.
// Inputs change 1-2 ns after the rising edge; the model samples on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_fifo_ahb_writer;
  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam int          WIN    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = '0;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic        busy;
  logic        err;
  logic [15:0] xfer_count;
  logic [2:0]  state_dbg;

  fifo_ahb_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .WIN_WORDS(WIN)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .busy(busy), .err(err), .xfer_count(xfer_count), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int          cyc = 0, pops = 0, exp_cnt = 0, acc_idx = 0, err_idx = -1;
  int          pop_cyc = 0, done_cyc = 0, wait_left = 0, err_stage = 0;
  int          min_wait = 0, max_wait = 0;
  bit          in_data = 0, inflight = 0, halted = 0, pop_now = 0;
  bit          err_this = 0, idle_stall = 0;
  logic        nxt_ready = 1'b1, nxt_resp = 1'b0;
  logic [31:0] exp_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_cnt(input int target, input int budget, input string tag);
    int k = 0;
    while (exp_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, (exp_cnt >= target), 1);
  endtask

  // ---------------- reference model: sample on falling edge ----------------
  initial forever begin
    @(negedge clk);
    cyc++;
    pop_now = 0;
    if (rst) begin
      if (inflight) void'(exp_q.pop_front());  // popped word is dropped by reset
      in_data = 0; inflight = 0; halted = 0; exp_cnt = 0; acc_idx = 0;
      err_stage = 0; nxt_ready = 1'b1; nxt_resp = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        check("pop_legal", {fifo_empty, inflight, halted, !enable}, 4'b0000);
        pop_now = 1; inflight = 1; pop_cyc = cyc; pops++;
      end
      if (in_data) begin
        check("data_htrans", HTRANS, 2'b00);
        check("hwdata", HWDATA, exp_q[0]);
        if (HREADY) begin
          in_data = 0; inflight = 0; done_cyc = cyc;
          void'(exp_q.pop_front());
          if (HRESP) halted = 1;
          else exp_cnt++;
        end
      end
      if (HTRANS == 2'b10) begin
        exp_addr = BASE + 32'((exp_cnt % WIN) * 4);
        check("haddr", HADDR, exp_addr);
        check("hwrite", HWRITE, 1'b1);
        if (HREADY) begin
          in_data   = 1;
          wait_left = int'($urandom_range(max_wait, min_wait));
          err_this  = (acc_idx == err_idx);
          err_stage = 0;
          acc_idx++;
        end
      end
      // Slave response for the next cycle
      if (in_data) begin
        if (wait_left > 0) begin
          wait_left--; nxt_ready = 1'b0; nxt_resp = 1'b0;
        end else if (err_this && err_stage == 0) begin
          err_stage = 1; nxt_ready = 1'b0; nxt_resp = 1'b1;
        end else begin
          nxt_ready = 1'b1; nxt_resp = err_this;
        end
      end else begin
        nxt_ready = idle_stall ? ($urandom_range(3, 0) != 0) : 1'b1;
        nxt_resp  = 1'b0;
      end
    end
  end

  // ---------------- FIFO and slave drivers: apply after rising edge ----------------
  initial forever begin
    @(posedge clk);
    #1;
    if (pop_now && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    HREADY     = nxt_ready;
    HRESP      = nxt_resp;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    // Reset values
    rst = 1'b1; enable = 1'b0;
    tick(3);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_hwrite", HWRITE, 1'b0);
    check("rst_haddr", HADDR, BASE);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_count", xfer_count, 16'h0);
    check("hsize", HSIZE, 3'b010);
    check("hburst", HBURST, 3'b000);
    rst = 1'b0;
    tick();

    // Single write, zero wait states
    push(32'hDEADBEEF);
    enable = 1'b1;
    wait_cnt(1, 50, "single_done");
    tick(2);
    check("single_count", xfer_count, 16'd1);
    check("single_busy", busy, 1'b0);
    check("single_latency", done_cyc - pop_cyc, 3);

    // Two wait states in every data phase
    min_wait = 2; max_wait = 2;
    for (int i = 0; i < 3; i++) push($urandom);
    wait_cnt(4, 100, "wait_done");
    tick(3);
    check("wait_count", xfer_count, 16'd4);
    check("wait_pops", pops, 4);

    // Window wrap with random waits and address-phase stalls
    min_wait = 0; max_wait = 3; idle_stall = 1;
    for (int i = 1; i <= 6; i++) push(32'(i));
    wait_cnt(10, 300, "wrap_done");
    tick(3);
    check("wrap_count", xfer_count, 16'd10);

    // Random data with enable toggling
    for (int i = 0; i < 20; i++) push($urandom);
    k = 0;
    while (exp_cnt < 30 && k < 800) begin
      enable = ($urandom_range(3, 0) != 0);
      tick();
      k++;
    end
    check("rand_done", (exp_cnt >= 30), 1);
    enable = 1'b1;
    tick(8);
    check("rand_count", xfer_count, 16'd30);

    // Drop enable while the address phase is on the bus
    idle_stall = 0; min_wait = 0; max_wait = 0;
    push($urandom); push($urandom);
    k = 0;
    while (HTRANS != 2'b10 && k < 50) begin
      tick();
      k++;
    end
    check("addr_seen", HTRANS, 2'b10);
    enable = 1'b0;
    tick(4);
    check("drop_count", xfer_count, 16'd31);
    check("drop_busy", busy, 1'b0);
    for (int i = 0; i < 20; i++) begin
      check("gate_off_rd_en", fifo_rd_en, 1'b0);
      check("gate_off_htrans", HTRANS, 2'b00);
      tick();
    end
    check("drop_fifo_left", fifo_q.size(), 1);

    // Re-enable drains the remaining word, then an empty FIFO stays idle
    enable = 1'b1;
    wait_cnt(32, 50, "drain_done");
    tick(3);
    for (int i = 0; i < 20; i++) begin
      check("gate_empty_rd_en", fifo_rd_en, 1'b0);
      check("gate_empty_htrans", HTRANS, 2'b00);
      tick();
    end
    check("drain_count", xfer_count, 16'd32);

    // Reset while the data phase is stalled
    min_wait = 8; max_wait = 8;
    push(32'hA5A5_5A5A);
    k = 0;
    while (!(in_data && HREADY == 1'b0) && k < 50) begin
      tick();
      k++;
    end
    check("stall_seen", in_data, 1'b1);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_count", xfer_count, 16'h0);
    check("mid_rst_haddr", HADDR, BASE);
    check("mid_rst_htrans", HTRANS, 2'b00);
    check("mid_rst_hwdata", HWDATA, 32'h0);
    check("mid_rst_rd_en", fifo_rd_en, 1'b0);
    check("mid_rst_err", err, 1'b0);
    rst = 1'b0;
    tick(2);
    check("mid_rst_lost", exp_q.size(), 0);

    // Second write answered with a two-cycle ERROR
    min_wait = 0; max_wait = 1; err_idx = 1;
    for (int i = 0; i < 4; i++) push($urandom);
    k = 0;
    while (!halted && k < 100) begin
      tick();
      k++;
    end
    check("err_seen", halted, 1'b1);
    tick(20);
    check("err_flag", err, 1'b1);
    check("err_count", xfer_count, 16'd1);
    check("err_busy", busy, 1'b1);
    check("err_htrans", HTRANS, 2'b00);
    check("err_fifo_left", fifo_q.size(), 2);

    // Only reset leaves the halted state
    enable = 1'b0;
    rst = 1'b1;
    tick();
    check("err_rst_err", err, 1'b0);
    check("err_rst_busy", busy, 1'b0);
    check("err_rst_count", xfer_count, 16'h0);
    rst = 1'b0;
    err_idx = -1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
